pc_sequencer: RTL

//  Fetch/PC controller. Computes next_PC for the PC register and runs the fetch handshake with instruction memory.

---
 rtl/pc_seq_pkg.sv | 26 ++
 rtl/pc_target_calc.sv | 39 +++
 rtl/pc_sequencer.sv | 114 +++++++++++
 3 files changed

// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the fetch/PC sequencer.
// The target calculator consumes the redirect request struct.
package pc_seq_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        HALT  = 2'd2
    } seq_state_e;

    localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] DEF_EXC_VECTOR   = 32'h0000_0180;
    localparam logic [31:0] PC_INC           = 32'd4;

    typedef struct packed {
        logic        exc;
        logic        eret;
        logic        jr;
        logic [31:0] jr_target;
        logic        jump;
        logic [25:0] jump_idx;
        logic        branch_taken;
        logic [31:0] branch_off;
    } redirect_req_t;

endpackage

// File: rtl/pc_target_calc.sv
// Pure combinational next-PC target selection.
// Sources are prioritised: exception, misaligned jr, eret, jr, jump, branch, then pc+4.
module pc_target_calc
    import pc_seq_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = DEF_EXC_VECTOR
) (
    input  logic [31:0]   pc,
    input  redirect_req_t req,
    input  logic [31:0]   epc,
    output logic [31:0]   target,
    output logic          jr_misalign
);

    logic [31:0] pc4;
    logic [31:0] br_target;
    logic [31:0] jmp_target;

    assign pc4        = pc + PC_INC;
    assign br_target  = pc4 + (req.branch_off << 2);
    assign jmp_target = {pc4[31:28], req.jump_idx, 2'b00};
    // Only a jr that is actually selected can fault; the caller gates with retire.
    assign jr_misalign = req.jr & (|req.jr_target[1:0]);

    always_comb begin
        target = pc4;
        if (req.exc || jr_misalign)
            target = EXC_VECTOR;
        else if (req.eret)
            target = epc;
        else if (req.jr)
            target = req.jr_target;
        else if (req.jump)
            target = jmp_target;
        else if (req.branch_taken)
            target = br_target;
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch/PC controller: drives next_PC, the imem handshake, redirects,
// exceptions with EPC, halt and the retired-instruction counter.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = DEF_RESET_VECTOR,
    parameter logic [31:0] EXC_VECTOR   = DEF_EXC_VECTOR
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] pc_i,
    output logic [31:0] next_pc_o,
    output logic        imem_req_o,
    input  logic        imem_ack_i,
    input  logic        stall_i,
    input  logic        branch_taken_i,
    input  logic [31:0] branch_off_i,
    input  logic        jump_i,
    input  logic [25:0] jump_idx_i,
    input  logic        jr_i,
    input  logic [31:0] jr_target_i,
    input  logic        exc_i,
    input  logic        eret_i,
    input  logic        halt_i,
    output logic        instr_valid_o,
    output logic [31:0] epc_o,
    output logic        misalign_o,
    output logic        halted_o,
    output logic [31:0] instret_o
);

    seq_state_e    state_q, state_d;
    redirect_req_t req;
    logic [31:0]   target;
    logic          jr_misalign;
    logic          retire;
    logic          decide;
    logic          mis_fire;
    logic          take_exc;

    assign req = '{
        exc:          exc_i,
        eret:         eret_i,
        jr:           jr_i,
        jr_target:    jr_target_i,
        jump:         jump_i,
        jump_idx:     jump_idx_i,
        branch_taken: branch_taken_i,
        branch_off:   branch_off_i
    };

    pc_target_calc #(.EXC_VECTOR(EXC_VECTOR)) u_calc (
        .pc          (pc_i),
        .req         (req),
        .epc         (epc_o),
        .target      (target),
        .jr_misalign (jr_misalign)
    );

    // A misaligned jr still retires (it was fetched and accepted) but vectors to the handler.
    assign retire   = (state_q == FETCH) & imem_ack_i & ~stall_i & ~exc_i;
    assign decide   = retire | (exc_i & (state_q != BOOT));
    assign mis_fire = retire & jr_misalign;
    assign take_exc = decide & (exc_i | mis_fire);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            state_q <= BOOT;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            BOOT:    state_d = FETCH;
            FETCH:   if (retire && halt_i) state_d = HALT;
            HALT:    if (exc_i) state_d = FETCH;
            default: state_d = BOOT;
        endcase
    end

    always_comb begin
        imem_req_o    = 1'b0;
        instr_valid_o = 1'b0;
        halted_o      = 1'b0;
        next_pc_o     = pc_i;
        if (!reset || state_q == BOOT) begin
            next_pc_o = RESET_VECTOR;
        end else begin
            imem_req_o    = (state_q == FETCH);
            instr_valid_o = retire;
            halted_o      = (state_q == HALT);
            if (decide)
                next_pc_o = target;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            epc_o      <= '0;
            misalign_o <= 1'b0;
            instret_o  <= '0;
        end else begin
            if (take_exc)
                epc_o <= pc_i;
            if (mis_fire)
                misalign_o <= 1'b1;
            if (retire)
                instret_o <= instret_o + 32'd1;
        end
    end

endmodule
